// File: rtl/gcd_operand_driver_if.sv
// Bundle of request, response and engine-side signals for gcd_operand_driver.
// slave = the driver itself; master = bus adapter plus GCD engine around it.
interface gcd_operand_driver_if #(
    parameter int W  = 16,
    parameter int CW = 8
);
    logic          op_valid;
    logic          op_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          gcd_start;
    logic [W-1:0]  gcd_data;
    logic          gcd_done;
    logic [W-1:0]  gcd_result;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic [CW-1:0] res_cycles;
    logic          res_err;

    modport slave (
        input  op_valid, op_a, op_b, gcd_done, gcd_result, res_ready,
        output op_ready, gcd_start, gcd_data, res_valid, res_data, res_cycles, res_err
    );

    modport master (
        output op_valid, op_a, op_b, gcd_done, gcd_result, res_ready,
        input  op_ready, gcd_start, gcd_data, res_valid, res_data, res_cycles, res_err
    );
endinterface

// File: rtl/gcd_operand_driver.sv
// GCD engine initiator: loads A then B, waits for done, returns result; watchdog via GCD_DRV_TIMEOUT_EN.
// Latency: accept -> res_valid is 3+N cycles (N engine WAIT cycles), 1 cycle for zero-operand bypass.
// Backpressure: one job in flight; op_ready only in IDLE, response held until res_ready.
module gcd_operand_driver #(
    parameter int W   = 16,
    parameter int CW  = 8,
    parameter int TMO = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gcd_operand_driver_if.slave  bus
);
`ifdef GCD_DRV_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int WDW = $clog2(TMO + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT, S_RESP} state_t;

    state_t         state;
    state_t         next_state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   res_data_q;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;
    logic [CW-1:0]  res_cycles_q;
    logic [WDW-1:0] wd_cnt;
    logic           res_err_q;
    logic           accept;
    logic           bypass;
    logic           timeout;

    assign accept  = (state == S_IDLE) && bus.op_valid;
    assign bypass  = (bus.op_a == '0) || (bus.op_b == '0);
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    // Watchdog has its own counter since res_cycles may saturate below TMO.
    assign timeout = TMO_EN && (state == S_WAIT) && !bus.gcd_done &&
                     (wd_cnt == WDW'(TMO - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept) next_state = bypass ? S_RESP : S_LOAD_A;
            S_LOAD_A: next_state = S_LOAD_B;
            S_LOAD_B: next_state = S_WAIT;
            S_WAIT:   if (bus.gcd_done || timeout) next_state = S_RESP;
            S_RESP:   if (bus.res_ready) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.op_ready  = 1'b0;
        bus.gcd_start = 1'b0;
        bus.gcd_data  = '0;
        bus.res_valid = 1'b0;
        case (state)
            S_IDLE:   bus.op_ready = rst_n;
            S_LOAD_A: begin
                bus.gcd_start = 1'b1;
                bus.gcd_data  = a_q;
            end
            S_LOAD_B: bus.gcd_data  = b_q;
            S_RESP:   bus.res_valid = 1'b1;
            default:  ;
        endcase
    end

    assign bus.res_data   = res_data_q;
    assign bus.res_cycles = res_cycles_q;
    assign bus.res_err    = res_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            res_data_q   <= '0;
            res_cycles_q <= '0;
            res_err_q    <= 1'b0;
            cnt          <= '0;
            wd_cnt       <= '0;
        end else begin
            if (accept) begin
                a_q       <= bus.op_a;
                b_q       <= bus.op_b;
                res_err_q <= 1'b0;
                if (bypass) begin
                    res_data_q   <= bus.op_a | bus.op_b;
                    res_cycles_q <= '0;
                end
            end
            if (state == S_LOAD_B) begin
                cnt    <= '0;
                wd_cnt <= '0;
            end
            // Done is only honoured here, so a stale done never completes a new job.
            if (state == S_WAIT) begin
                cnt    <= cnt_inc;
                wd_cnt <= wd_cnt + 1'b1;
                if (bus.gcd_done) begin
                    res_data_q   <= bus.gcd_result;
                    res_cycles_q <= cnt_inc;
                end else if (timeout) begin
                    res_err_q    <= 1'b1;
                    res_data_q   <= '0;
                    res_cycles_q <= cnt_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_gcd_operand_driver.sv
// Scoreboard bench for gcd_operand_driver with a behavioural GCD engine model.
module tb_gcd_operand_driver;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    gcd_operand_driver_if #(.W(16), .CW(8)) bif ();

    gcd_operand_driver #(.W(16), .CW(8), .TMO(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] dat;
        int          cycles;
        bit          err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_a = 0;
    logic [15:0] exp_b = 0;
    logic [15:0] eng_a;
    logic [15:0] eng_b;
    int          eng_lat = -1;
    bit          eng_abort = 0;
    bit          stale_idle = 0;
    bit          done_in_lb = 0;
    int          start_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic logic [15:0] gcd_fn(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] t;
        a = x;
        b = y;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Engine model: done is raised in the eng_lat-th WAIT cycle.
    initial begin : engine
        int k;
        bif.gcd_done   = 1'b0;
        bif.gcd_result = '0;
        forever begin
            @(negedge clk);
            bif.gcd_done   = stale_idle;
            bif.gcd_result = stale_idle ? 16'd99 : 16'd0;
            if (bif.gcd_start === 1'b1) begin
                start_cnt++;
                eng_a = bif.gcd_data;
                chk("load_a_data", eng_a, exp_a);
                @(negedge clk);
                eng_b = bif.gcd_data;
                chk("start_one_cycle", bif.gcd_start, 0);
                chk("load_b_data", eng_b, exp_b);
                bif.gcd_done   = done_in_lb;
                bif.gcd_result = 16'd77;
                k = 0;
                forever begin
                    @(negedge clk);
                    k++;
                    bif.gcd_done = 1'b0;
                    if (k == 1) chk("wait_data_zero", bif.gcd_data, 0);
                    if (eng_abort || (eng_lat > 0 && k > eng_lat)) break;
                    if (k == eng_lat) begin
                        bif.gcd_done   = 1'b1;
                        bif.gcd_result = gcd_fn(eng_a, eng_b);
                    end
                end
            end
        end
    end

    // Response monitor: latency on rising res_valid, content at handshake.
    initial begin : monitor
        bit          prev_vld;
        bit          held_ok;
        bit          hs_pending;
        logic [15:0] held_dat;
        exp_t        e;
        prev_vld   = 0;
        held_ok    = 1;
        hs_pending = 0;
        held_dat   = 0;
        forever begin
            @(negedge clk);
            if (hs_pending) begin
                chk("op_ready_after_handshake", bif.op_ready, 1);
                hs_pending = 0;
            end
            if (bif.res_valid === 1'b1) begin
                if (!prev_vld) begin
                    held_dat = bif.res_data;
                    held_ok  = (bif.op_ready === 1'b0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp got res_data=%0d expected no response", bif.res_data);
                    end else begin
                        chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
                    end
                end else if (bif.res_data !== held_dat || bif.op_ready !== 1'b0) begin
                    held_ok = 0;
                end
                if (bif.res_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("res_data", bif.res_data, e.dat);
                    chk("res_cycles", bif.res_cycles, e.cycles);
                    chk("res_err", bif.res_err, e.err);
                    chk("held_stable", held_ok, 1);
                    hs_pending = 1;
                end
            end
            prev_vld = (bif.res_valid === 1'b1);
        end
    end

    task automatic send_op(input logic [15:0] a, input logic [15:0] b, input int lat_eng,
                           input logic [15:0] d, input int c, input bit e, input int lat,
                           input bit push);
        int   n;
        exp_t ent;
        n       = 0;
        exp_a   = a;
        exp_b   = b;
        eng_lat = lat_eng;
        @(posedge clk); #1;
        bif.op_valid = 1'b1;
        bif.op_a     = a;
        bif.op_b     = b;
        forever begin
            @(negedge clk);
            if (bif.op_ready === 1'b1) break;
            n++;
            if (n > 400) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout got op_ready=0 expected 1 within 400 cycles");
                break;
            end
        end
        ent = '{dat: d, cycles: c, err: e, lat: lat, acc: cyc};
        if (push) exp_q.push_back(ent);
        @(posedge clk); #1;
        bif.op_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int n;
        int s0;
        rst_n         = 1'b0;
        bif.op_valid  = 1'b0;
        bif.op_a      = '0;
        bif.op_b      = '0;
        bif.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_op_ready", bif.op_ready, 0);
        chk("rst_gcd_start", bif.gcd_start, 0);
        chk("rst_gcd_data", bif.gcd_data, 0);
        chk("rst_res_valid", bif.res_valid, 0);
        chk("rst_res_data", bif.res_data, 0);
        chk("rst_res_cycles", bif.res_cycles, 0);
        chk("rst_res_err", bif.res_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("op_ready_after_reset", bif.op_ready, 1);

        // Normal job: 36,24 with engine done in 5th WAIT cycle.
        send_op(16'd36, 16'd24, 5, 16'd12, 5, 0, 8, 1);
        wait_drain();

        // Zero-operand bypass never touches the engine.
        s0 = start_cnt;
        send_op(16'd0, 16'd7, -1, 16'd7, 0, 0, 1, 1);
        send_op(16'd9, 16'd0, -1, 16'd9, 0, 0, 1, 1);
        send_op(16'd0, 16'd0, -1, 16'd0, 0, 0, 1, 1);
        wait_drain();
        chk("bypass_no_start", start_cnt, s0);

        // Response backpressure for 10 cycles.
        bif.res_ready = 1'b0;
        send_op(16'd48, 16'd18, 3, 16'd6, 3, 0, 6, 1);
        n = 0;
        while (bif.res_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_res_valid_seen", bif.res_valid, 1);
        repeat (10) @(posedge clk);
        #1;
        bif.res_ready = 1'b1;
        wait_drain();

        // Reset mid-WAIT: silent abort, then a clean job.
        send_op(16'd100, 16'd75, -1, 16'd0, 0, 0, 0, 0);
        repeat (6) @(posedge clk);
        eng_abort = 1;
        pulse_reset();
        @(negedge clk);
        chk("midrst_op_ready", bif.op_ready, 1);
        chk("midrst_res_valid", bif.res_valid, 0);
        eng_abort = 0;
        repeat (3) @(posedge clk);
        send_op(16'd15, 16'd10, 2, 16'd5, 2, 0, 5, 1);
        wait_drain();

        // Stale done in IDLE and done in LOAD_B are both ignored.
        stale_idle = 1;
        done_in_lb = 1;
        repeat (3) @(posedge clk);
        send_op(16'd21, 16'd14, 4, 16'd7, 4, 0, 7, 1);
        stale_idle = 0;
        wait_drain();
        done_in_lb = 0;

`ifdef GCD_DRV_TIMEOUT_EN
        send_op(16'd5, 16'd3, -1, 16'd0, 16, 1, 19, 1);
        wait_drain();
        eng_abort = 1;
        pulse_reset();
        @(negedge clk);
        eng_abort = 0;
        send_op(16'd36, 16'd24, 5, 16'd12, 5, 0, 8, 1);
        wait_drain();
`else
        // res_cycles saturates at 255.
        send_op(16'd7, 16'd7, 300, 16'd7, 255, 0, 303, 1);
        wait_drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
